branch_pc_unit: RTL and testbench

- Program-counter and branch-resolution stage directly downstream of the 8-bit execute ALU.
- Consumes the ALU ZERO flag together with decoded branch controls, then drives the next instruction address to fetch.
- Supports relative branches (signed offset) and absolute branches (target from a constant lookup table), halt, and pipeline stall.
- Emits a one-cycle FLUSH on a taken branch so the fetched-but-wrong instruction is squashed.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/branch_pc_unit_if.sv | 30 +++
 rtl/branch_pc_unit_target.sv | 31 +++
 rtl/branch_pc_unit.sv | 112 +++++++++++
 tb/tb_branch_pc_unit.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the branch/PC stage: FSM state encoding,
// default widths and the absolute-branch target table.
package cpu_pkg;

    localparam int DEF_PC_W  = 10;
    localparam int DEF_OFF_W = 8;
    localparam int DEF_IDX_W = 4;
    localparam int LUT_N     = 2 ** DEF_IDX_W;
    localparam int LUT_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    // Absolute branch targets: entry i holds 4*i.
    localparam logic [LUT_W-1:0] BR_LUT [LUT_N] = '{
        16'd0,  16'd4,  16'd8,  16'd12, 16'd16, 16'd20, 16'd24, 16'd28,
        16'd32, 16'd36, 16'd40, 16'd44, 16'd48, 16'd52, 16'd56, 16'd60
    };

endpackage

// File: rtl/branch_pc_unit_if.sv
// Control/status bundle between the execute stage and the PC unit.
interface branch_pc_unit_if #(
    parameter int PC_W  = 10,
    parameter int OFF_W = 8,
    parameter int IDX_W = 4
);
    logic             START;
    logic             STALL;
    logic             HALT_REQ;
    logic             BR_EN;
    logic             BR_ON_ZERO;
    logic             BR_ABS;
    logic [IDX_W-1:0] BR_IDX;
    logic [OFF_W-1:0] BR_OFF;
    logic             ZERO;
    logic [PC_W-1:0]  PC;
    logic             PC_VALID;
    logic             FLUSH;
    logic             DONE;

    modport master (
        output START, STALL, HALT_REQ, BR_EN, BR_ON_ZERO, BR_ABS, BR_IDX, BR_OFF, ZERO,
        input  PC, PC_VALID, FLUSH, DONE
    );

    modport slave (
        input  START, STALL, HALT_REQ, BR_EN, BR_ON_ZERO, BR_ABS, BR_IDX, BR_OFF, ZERO,
        output PC, PC_VALID, FLUSH, DONE
    );
endinterface

// File: rtl/branch_pc_unit_target.sv
// Combinational branch target: PC-relative (sign-extended offset, wrapping)
// or absolute via the constant table.
module branch_target
    import cpu_pkg::*;
#(
    parameter int PC_W  = DEF_PC_W,
    parameter int OFF_W = DEF_OFF_W,
    parameter int IDX_W = DEF_IDX_W
) (
    input  logic [PC_W-1:0]  pc,
    input  logic             br_abs,
    input  logic [IDX_W-1:0] br_idx,
    input  logic [OFF_W-1:0] br_off,
    output logic [PC_W-1:0]  target
);
    logic [PC_W-1:0] off_ext_s;
    logic [PC_W-1:0] rel_s;
    logic [PC_W-1:0] abs_s;

    // Select between relative and table-driven targets.
    always_comb begin
        off_ext_s = PC_W'($signed(br_off));
        rel_s     = pc + off_ext_s;
        abs_s     = PC_W'(BR_LUT[DEF_IDX_W'(br_idx)]);
        if (br_abs) begin
            target = abs_s;
        end else begin
            target = rel_s;
        end
    end
endmodule

// File: rtl/branch_pc_unit.sv
// PC sequencing and branch resolution stage: IDLE/RUN/HALTED FSM with
// registered PC, PC_VALID, FLUSH and DONE.
module branch_pc_unit
    import cpu_pkg::*;
#(
    parameter int PC_W  = DEF_PC_W,
    parameter int OFF_W = DEF_OFF_W,
    parameter int IDX_W = DEF_IDX_W
) (
    input logic              CLK,
    input logic              RESET_N,
    branch_pc_unit_if.slave  bus
);
    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            pc_valid_q, pc_valid_d;
    logic            flush_q, flush_d;
    logic            done_q, done_d;
    logic [PC_W-1:0] target_s;
    logic            taken_s;

    branch_target #(
        .PC_W  (PC_W),
        .OFF_W (OFF_W),
        .IDX_W (IDX_W)
    ) u_target (
        .pc     (pc_q),
        .br_abs (bus.BR_ABS),
        .br_idx (bus.BR_IDX),
        .br_off (bus.BR_OFF),
        .target (target_s)
    );

    assign taken_s = bus.BR_EN && (bus.ZERO == bus.BR_ON_ZERO);

    // Next-state and next-output logic; FLUSH defaults low so it can only pulse.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_valid_d = pc_valid_q;
        flush_d    = 1'b0;
        done_d     = done_q;
        case (state_q)
            ST_IDLE: begin
                pc_d   = {PC_W{1'b0}};
                done_d = 1'b0;
                if (bus.START) begin
                    state_d    = ST_RUN;
                    pc_valid_d = 1'b1;
                end else begin
                    state_d    = ST_IDLE;
                    pc_valid_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (bus.STALL) begin
                    state_d = ST_RUN;
                end else if (bus.HALT_REQ) begin
                    state_d    = ST_HALTED;
                    pc_valid_d = 1'b0;
                    done_d     = 1'b1;
                end else if (taken_s) begin
                    pc_d    = target_s;
                    flush_d = 1'b1;
                end else begin
                    pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
                end
            end
            ST_HALTED: begin
                // STALL is deliberately not consulted here.
                if (bus.START) begin
                    state_d    = ST_RUN;
                    pc_d       = {PC_W{1'b0}};
                    pc_valid_d = 1'b1;
                    done_d     = 1'b0;
                end else begin
                    state_d    = ST_HALTED;
                    pc_valid_d = 1'b0;
                    done_d     = 1'b1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                pc_d       = {PC_W{1'b0}};
                pc_valid_d = 1'b0;
                done_d     = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            pc_q       <= {PC_W{1'b0}};
            pc_valid_q <= 1'b0;
            flush_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
            flush_q    <= flush_d;
            done_q     <= done_d;
        end
    end

    assign bus.PC       = pc_q;
    assign bus.PC_VALID = pc_valid_q;
    assign bus.FLUSH    = flush_q;
    assign bus.DONE     = done_q;
endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed scoreboard bench for branch_pc_unit: expected outputs are queued
// as each cycle's stimulus is applied and checked after the clock edge.
module tb_branch_pc_unit;
    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    typedef struct {
        logic [9:0] pc;
        logic       valid;
        logic       flush;
        logic       done;
        string      tag;
    } exp_t;

    exp_t sb[$];

    branch_pc_unit_if #(.PC_W(10), .OFF_W(8), .IDX_W(4)) bus ();

    branch_pc_unit #(.PC_W(10), .OFF_W(8), .IDX_W(4)) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [9:0] pc, input logic v, input logic f, input logic d,
                        input string tag);
        exp_t e;
        e.pc = pc; e.valid = v; e.flush = f; e.done = d; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        n_assert++;
        assert (sb.size() > 0) else begin
            n_fail++;
            $error("FAIL scoreboard observed=empty expected=entry");
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, ".pc"},    16'(bus.PC),       16'(e.pc));
            chk({e.tag, ".valid"}, 16'(bus.PC_VALID), 16'(e.valid));
            chk({e.tag, ".flush"}, 16'(bus.FLUSH),    16'(e.flush));
            chk({e.tag, ".done"},  16'(bus.DONE),     16'(e.done));
        end else begin
            n_assert = n_assert;
        end
    endtask

    // One clock: inputs applied at the falling edge, outputs checked 1 after the rising edge.
    task automatic cyc(input logic start, input logic stall, input logic halt,
                       input logic br_en, input logic on_z, input logic br_abs,
                       input logic [3:0] idx, input logic [7:0] off, input logic zero,
                       input logic [9:0] epc, input logic ev, input logic ef,
                       input logic ed, input string tag);
        @(negedge clk);
        bus.START = start; bus.STALL = stall; bus.HALT_REQ = halt;
        bus.BR_EN = br_en; bus.BR_ON_ZERO = on_z; bus.BR_ABS = br_abs;
        bus.BR_IDX = idx; bus.BR_OFF = off; bus.ZERO = zero;
        push(epc, ev, ef, ed, tag);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic nop(input logic [9:0] epc, input string tag);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, epc, 1'b1, 1'b0, 1'b0, tag);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.START = 1'b0; bus.STALL = 1'b0; bus.HALT_REQ = 1'b0;
        bus.BR_EN = 1'b0; bus.BR_ON_ZERO = 1'b0; bus.BR_ABS = 1'b0;
        bus.BR_IDX = 4'd0; bus.BR_OFF = 8'd0; bus.ZERO = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        push(10'd0, 1'b0, 1'b0, 1'b0, "reset");
        check_out();
        @(negedge clk);
        rst_n = 1'b1;

        // Idle without START, then start and count up
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, "idle");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0, "start");
        for (int k = 1; k <= 5; k++) nop(10'(k), "count");

        // Relative backward taken at PC=5
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 8'hFD, 1'b1, 10'd2, 1'b1, 1'b1, 1'b0, "rel_back");
        for (int k = 3; k <= 7; k++) nop(10'(k), "after_rel");

        // Not taken at PC=7, then absolute idx 3 at PC=8
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 10'd8, 1'b1, 1'b0, 1'b0, "not_taken");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 8'd0, 1'b0, 10'd12, 1'b1, 1'b1, 1'b0, "abs_idx3");

        // Stall beats taken branch; then halt beats branch
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd5, 8'd0, 1'b1, 10'd12, 1'b1, 1'b0, 1'b0, "stall");
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd5, 8'd0, 1'b1, 10'd12, 1'b0, 1'b0, 1'b1, "halt");
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 8'd4, 1'b1, 10'd12, 1'b0, 1'b0, 1'b1, "halted_hold");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0, "restart");

        // Back-to-back taken +127 jumps toward the top of the address space
        for (int k = 1; k <= 8; k++)
            cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd127, 1'b0,
                10'(127 * k), 1'b1, 1'b1, 1'b0, "rel_fwd");
        for (int k = 1017; k <= 1023; k++) nop(10'(k), "climb");
        nop(10'd0, "wrap_inc");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'hFF, 1'b0, 10'd1023, 1'b1, 1'b1, 1'b0, "wrap_neg");
        nop(10'd0, "wrap_again");

        // Async reset between edges at PC=37
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 8'd37, 1'b1, 10'd37, 1'b1, 1'b1, 1'b0, "to37");
        #2;
        rst_n = 1'b0;
        #1;
        push(10'd0, 1'b0, 1'b0, 1'b0, "async_rst");
        check_out();
        @(negedge clk);
        rst_n = 1'b1;

        // START ignored in RUN; HALTED -> START resets PC
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0, "start2");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 10'd1, 1'b1, 1'b0, 1'b0, "start_in_run");
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 10'd1, 1'b0, 1'b0, 1'b1, "halt2");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0, "restart2");
        nop(10'd1, "post_restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
